icache_refill_master: RTL and testbench



---
 rtl/icache_refill_master_if.sv | 25 ++
 rtl/icache_refill_master.sv | 135 +++++++++++++
 tb/tb_icache_refill_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_master_if.sv
// AXI read-channel subset (AR + R) between the refill master and instruction memory.
// Only the fields the single-burst refill needs are carried.
interface axi_read_if #(
   parameter int AXI_ADDR_WIDTH = 32
);
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic [7:0]                arlen;
   logic                      arvalid;
   logic                      arready;
   logic [31:0]               rdata;
   logic [1:0]                rresp;
   logic                      rvalid;
   logic                      rlast;
   logic                      rready;

   modport master (
      output araddr, arlen, arvalid, rready,
      input  arready, rdata, rresp, rvalid, rlast
   );

   modport slave (
      input  araddr, arlen, arvalid, rready,
      output arready, rdata, rresp, rvalid, rlast
   );
endinterface

// File: rtl/icache_refill_master.sv
// Refills one icache line per request with a single AXI INCR burst; BEATS+2 cycles minimum.
// Stalls on arready/rvalid; req_ready is low from accept until the response pulse has gone.
module icache_refill_master #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int LINE_BYTES     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
   output logic                      req_ready,
   output logic                      resp_valid,
   output logic [LINE_BYTES*8-1:0]   resp_data,
   output logic                      resp_err,
   axi_read_if.master                axi_if
);
   localparam int BEATS = LINE_BYTES / 4;
   localparam int CNT_W = $clog2(BEATS) + 1;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]          LAST_CNT  = CNT_W'(BEATS - 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = ~AXI_ADDR_WIDTH'(LINE_BYTES - 1);

   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

   state_t                    state_q, state_d;
   logic                      req_ready_q, req_ready_d;
   logic                      arvalid_q, arvalid_d;
   logic                      rready_q, rready_d;
   logic                      resp_valid_q, resp_valid_d;
   logic                      resp_err_q, resp_err_d;
   logic                      err_q, err_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
   logic [BEATS-1:0][31:0]    line_q, line_d;

   logic r_hs;
   logic at_last_slot;

   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      err_d        = err_q;
      araddr_d     = araddr_q;
      beat_cnt_d   = beat_cnt_q;
      line_d       = line_q;
      r_hs         = rready_q && axi_if.rvalid;
      at_last_slot = (beat_cnt_q == LAST_CNT);

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               state_d     = AR;
               req_ready_d = 1'b0;
               arvalid_d   = 1'b1;
               araddr_d    = req_addr & LINE_MASK;
               line_d      = '0;
               beat_cnt_d  = '0;
               err_d       = 1'b0;
            end
         end
         AR: begin
            if (axi_if.arready) begin
               state_d   = R;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         R: begin
            if (r_hs) begin
               line_d[beat_cnt_q[IDX_W-1:0]] = axi_if.rdata;
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               err_d      = err_q | (axi_if.rresp != 2'b00);
               // The burst ends on whichever comes first; disagreement is a protocol error.
               if (axi_if.rlast || at_last_slot) begin
                  err_d        = err_d | (axi_if.rlast != at_last_slot);
                  state_d      = DONE;
                  rready_d     = 1'b0;
                  resp_valid_d = 1'b1;
                  resp_err_d   = err_d;
               end
            end
         end
         DONE: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         err_q        <= 1'b0;
         araddr_q     <= '0;
         beat_cnt_q   <= '0;
         line_q       <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         err_q        <= err_d;
         araddr_q     <= araddr_d;
         beat_cnt_q   <= beat_cnt_d;
         line_q       <= line_d;
      end
   end

   // arlen never changes, so it is stable across the whole burst by construction.
   assign axi_if.araddr  = araddr_q;
   assign axi_if.arlen   = 8'(BEATS - 1);
   assign axi_if.arvalid = arvalid_q;
   assign axi_if.rready  = rready_q;
   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_err       = resp_err_q;
   assign resp_data      = line_q;
endmodule

// File: tb/tb_icache_refill_master.sv
// Bench for icache_refill_master: table-driven directed fills, hand sequences, randomized fills.
module tb_icache_refill_master;
   localparam int AW = 32;
   localparam int LB = 32;
   localparam int NB = LB / 4;
   localparam int DW = LB * 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic          req_ready;
   logic          resp_valid;
   logic [DW-1:0] resp_data;
   logic          resp_err;

   axi_read_if #(.AXI_ADDR_WIDTH(AW)) axi ();

   icache_refill_master #(.AXI_ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .axi_if     (axi.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] last_data;

   typedef struct {
      logic [31:0] addr;
      int          ar_delay;
      int          throttle;   // 0 none, 1 alternate, 2 random
      int          err_beat;   // 1-based beat with bad rresp, 0 none
      int          last_beat;  // 1-based beat carrying rlast, NB+1 = never
      logic [31:0] base;
      logic [31:0] exp_araddr;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the line holds base+k in every slot the slave actually delivered, zero elsewhere.
   function automatic logic [DW-1:0] model_line(input logic [31:0] base, input int last_beat);
      logic [DW-1:0] l;
      int n;
      l = '0;
      n = (last_beat < NB) ? last_beat : NB;
      for (int k = 0; k < n; k++) l[k*32 +: 32] = base + 32'(k);
      return l;
   endfunction

   function automatic bit model_err(input int err_beat, input int last_beat);
      int n;
      n = (last_beat < NB) ? last_beat : NB;
      return (err_beat >= 1 && err_beat <= n) || (last_beat != NB);
   endfunction

   task automatic run_fill(input logic [31:0] addr, input int ar_delay, input int throttle,
                           input int err_beat, input logic [1:0] err_code, input int last_beat,
                           input logic [31:0] base, input logic [31:0] exp_araddr,
                           input bit exp_err, input logic [DW-1:0] exp_data,
                           input bit keep_valid, input int rst_beat, output int accept_cyc);
      int n_send, cyc, acc, first_ar, ar_cnt, ar_hs, sent, last_hs, resp_at;
      bit addr_ok, rr_early, allow, aborted;
      logic [AW-1:0] seen_araddr;
      logic [DW-1:0] got_data;
      logic          got_err;
      n_send = (last_beat < NB) ? last_beat : NB;
      cyc = 0; acc = -1; first_ar = -1; ar_cnt = 0; ar_hs = 0; sent = 0;
      last_hs = -1; resp_at = -1; addr_ok = 1; rr_early = 0; aborted = 0;
      seen_araddr = 'x; got_data = 'x; got_err = 1'bx;
      req_valid = 1'b1;
      req_addr  = addr;
      while (resp_at < 0 && cyc < 400) begin
         axi.arready = (ar_cnt >= ar_delay);
         allow = (throttle == 0) || (throttle == 1 && cyc % 2 == 0) ||
                 (throttle == 2 && $urandom_range(0, 1) == 1);
         if (ar_hs > 0 && sent < n_send && allow) begin
            axi.rvalid = 1'b1;
            axi.rdata  = base + 32'(sent);
            axi.rlast  = (sent + 1 == last_beat);
            axi.rresp  = (sent + 1 == err_beat) ? err_code : 2'b00;
         end else begin
            axi.rvalid = 1'b0;
            axi.rdata  = '0;
            axi.rlast  = 1'b0;
            axi.rresp  = 2'b00;
         end
         if (acc < 0 && req_valid && req_ready) acc = cyc;
         if (axi.rready && ar_hs == 0) rr_early = 1;
         if (axi.arvalid) begin
            if (first_ar < 0) begin
               first_ar    = cyc;
               seen_araddr = axi.araddr;
            end
            ar_cnt++;
            if (axi.arready) ar_hs++;
         end
         if (first_ar >= 0 && (axi.araddr !== exp_araddr || axi.arlen !== 8'(NB - 1))) addr_ok = 0;
         if (axi.rvalid && axi.rready) begin
            sent++;
            last_hs = cyc;
         end
         if (resp_valid) begin
            resp_at  = cyc;
            got_data = resp_data;
            got_err  = resp_err;
         end
         @(negedge clk);
         cyc++;
         if (acc >= 0 && !keep_valid) req_valid = 1'b0;
         if (rst_beat > 0 && sent == rst_beat) begin
            rst = 1'b1;
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            #1;
            chk("rst_arvalid", DW'(axi.arvalid), '0);
            chk("rst_rready", DW'(axi.rready), '0);
            chk("rst_resp_valid", DW'(resp_valid), '0);
            chk("rst_req_ready", DW'(req_ready), DW'(1));
            chk("rst_resp_data", resp_data, '0);
            @(negedge clk);
            chk("rst_no_resp", DW'(resp_valid), '0);
            rst = 1'b0;
            req_valid = 1'b0;
            aborted = 1;
            break;
         end
      end
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      accept_cyc = acc;
      if (!aborted) begin
         chk("resp_seen", DW'(resp_at >= 0), DW'(1));
         chk("ar_after_accept", DW'(first_ar), DW'(acc + 1));
         chk("araddr", DW'(seen_araddr), DW'(exp_araddr));
         chk("ar_handshakes", DW'(ar_hs), DW'(1));
         chk("arvalid_cycles", DW'(ar_cnt), DW'(ar_delay + 1));
         chk("ar_stable", DW'(addr_ok), DW'(1));
         chk("rready_early", DW'(rr_early), '0);
         chk("beats", DW'(sent), DW'(n_send));
         chk("resp_latency", DW'(resp_at), DW'(last_hs + 1));
         chk("resp_data", got_data, exp_data);
         chk("resp_err", DW'(got_err), DW'(exp_err));
         chk("resp_pulse", DW'(resp_valid), '0);
         chk("ready_after", DW'(req_ready), DW'(1));
         chk("data_held", resp_data, exp_data);
         last_data = got_data;
      end
   endtask

   initial begin
      int acc;
      logic [31:0] a, b;
      int d, th, eb, lb;
      vecs[0] = '{32'h0000_0044, 0, 0, 0, NB,     32'h11,  32'h0000_0040, 1'b0};
      vecs[1] = '{32'h1234_5678, 5, 0, 0, NB,     32'hA0,  32'h1234_5660, 1'b0};
      vecs[2] = '{32'h0000_0100, 0, 1, 0, NB,     32'h200, 32'h0000_0100, 1'b0};
      vecs[3] = '{32'h8000_001F, 0, 0, 3, NB,     32'h300, 32'h8000_0000, 1'b1};
      vecs[4] = '{32'h0000_00E4, 2, 0, 0, 5,      32'h400, 32'h0000_00E0, 1'b1};
      vecs[5] = '{32'hFFFF_FFFF, 1, 1, 0, NB + 1, 32'h500, 32'hFFFF_FFE0, 1'b1};

      rst = 1'b1; req_valid = 1'b0; req_addr = '0;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", DW'(req_ready), DW'(1));
      chk("reset_arvalid", DW'(axi.arvalid), '0);
      chk("reset_araddr", DW'(axi.araddr), '0);
      chk("reset_arlen", DW'(axi.arlen), DW'(NB - 1));
      chk("reset_rready", DW'(axi.rready), '0);
      chk("reset_resp_valid", DW'(resp_valid), '0);
      chk("reset_resp_data", resp_data, '0);
      chk("reset_resp_err", DW'(resp_err), '0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_fill(vecs[i].addr, vecs[i].ar_delay, vecs[i].throttle, vecs[i].err_beat, 2'b10,
                  vecs[i].last_beat, vecs[i].base, vecs[i].exp_araddr, vecs[i].exp_err,
                  model_line(vecs[i].base, vecs[i].last_beat), 1'b0, 0, acc);
         if (i == 0) begin
            chk("normal_word0", DW'(last_data[31:0]), DW'(32'h11));
            chk("normal_word7", DW'(last_data[255:224]), DW'(32'h18));
         end
         if (i == 4) chk("early_slots_5_7", DW'(last_data[255:160]), '0);
      end

      // Requester holds req_valid: the second accept lands the cycle after resp_valid drops.
      run_fill(32'h0000_2008, 0, 0, 0, 2'b10, NB, 32'h600, 32'h0000_2000, 1'b0,
               model_line(32'h600, NB), 1'b1, 0, acc);
      run_fill(32'h0000_2008, 0, 0, 0, 2'b10, NB, 32'h700, 32'h0000_2000, 1'b0,
               model_line(32'h700, NB), 1'b0, 0, acc);
      chk("b2b_accept", DW'(acc), '0);

      run_fill(32'h0000_3010, 0, 0, 0, 2'b10, NB, 32'h800, 32'h0000_3000, 1'b0,
               model_line(32'h800, NB), 1'b0, 4, acc);
      run_fill(32'h0000_4030, 1, 0, 0, 2'b10, NB, 32'h900, 32'h0000_4020, 1'b0,
               model_line(32'h900, NB), 1'b0, 0, acc);

      for (int t = 0; t < 30; t++) begin
         a  = $urandom;
         b  = $urandom;
         d  = $urandom_range(0, 3);
         th = $urandom_range(0, 2);
         eb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NB) : 0;
         lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NB + 1) : NB;
         run_fill(a, d, th, eb, 2'($urandom_range(1, 3)), lb, b, a & ~32'(LB - 1),
                  model_err(eb, lb), model_line(b, lb), 1'b0, 0, acc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
